// File: rtl/gearbox_66_40_feeder.sv
// gearbox_66_40_feeder: sequences a 66-to-40 gearbox (sclr/startup), buffers
// upstream 66-bit blocks in a small FIFO, advances gb_din on gb_ack, inserts
// IDLE blocks on underflow and checks the 20-acks-per-33-cycles cadence.
// Optional statistics counters are built when GB_FEED_STATS_EN is defined.
module gearbox_66_40_feeder #(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned SCLR_CYCLES = 4,
  parameter int unsigned PRIME_LEVEL = 2,
  parameter logic [65:0] IDLE_BLOCK  = 66'h79
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        restart,
  input  logic [65:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [65:0] gb_din,
  output logic        gb_sclr,
  input  logic        gb_ack,
  output logic        running,
  output logic        underflow,
  output logic        ack_err,
  output logic [15:0] underflow_cnt,
  output logic [31:0] block_cnt
);

  localparam int unsigned BW  = 66;
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = AW + 1;
  localparam int unsigned HCW = (SCLR_CYCLES > 2) ? $clog2(SCLR_CYCLES) : 1;
  localparam int unsigned WW  = 6;
  localparam logic [WW-1:0] WIN_LAST     = WW'(32);
  localparam logic [WW-1:0] ACKS_PER_WIN = WW'(20);

  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t         state, next_state;
  logic [HCW-1:0] hold_cnt;

  logic [BW-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  occ;
  logic           fifo_empty, fifo_full, flush, push, pop, underflow_evt;

  logic [WW-1:0]  win_cnt, win_acks, win_acks_total;
  logic           win_dirty;

  assign fifo_empty    = (occ == '0);
  assign fifo_full     = (occ == CW'(FIFO_DEPTH));
  assign in_ready      = (state != ST_HOLD) && !fifo_full;
  assign flush         = restart || (state == ST_HOLD);
  assign push          = in_valid && in_ready && !restart;
  assign pop           = gb_ack && (state == ST_RUN) && !fifo_empty && !restart;
  assign underflow_evt = gb_ack && (state == ST_RUN) && fifo_empty && !restart;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_HOLD;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    if (restart) begin
      next_state = ST_HOLD;
    end else begin
      case (state)
        ST_HOLD:  if (hold_cnt == '0) next_state = ST_PRIME;
        ST_PRIME: if (occ >= CW'(PRIME_LEVEL)) next_state = ST_RUN;
        ST_RUN:   next_state = ST_RUN;
        default:  next_state = ST_HOLD;
      endcase
    end
  end

  // Sync-clear hold down-counter, reloaded on every re-init
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               hold_cnt <= HCW'(SCLR_CYCLES - 1);
    else if (restart)                         hold_cnt <= HCW'(SCLR_CYCLES - 1);
    else if (state == ST_HOLD && hold_cnt != '0) hold_cnt <= hold_cnt - HCW'(1);
  end

  // FIFO pointers and occupancy; flushed while holding or on restart
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
    end
  end

  // FIFO storage (data only, no reset needed)
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // Gearbox-facing registers: din, sclr, running, sticky underflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gb_din    <= IDLE_BLOCK;
      gb_sclr   <= 1'b1;
      running   <= 1'b0;
      underflow <= 1'b0;
    end else begin
      gb_sclr <= (next_state == ST_HOLD);
      running <= (next_state == ST_RUN);
      if (restart) begin
        gb_din    <= IDLE_BLOCK;
        underflow <= 1'b0;
      end else if (gb_ack) begin
        gb_din <= pop ? mem[rd_ptr] : IDLE_BLOCK;
        if (underflow_evt) underflow <= 1'b1;
      end
    end
  end

  assign win_acks_total = win_acks + WW'(gb_ack);

  // Cadence monitor: 33-cycle windows, only fully-RUN windows are judged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt   <= '0;
      win_acks  <= '0;
      win_dirty <= 1'b0;
      ack_err   <= 1'b0;
    end else if (restart || gb_sclr) begin
      win_cnt   <= '0;
      win_acks  <= '0;
      win_dirty <= 1'b0;
      if (restart) ack_err <= 1'b0;
    end else if (win_cnt == WIN_LAST) begin
      if (state == ST_RUN && !win_dirty && win_acks_total != ACKS_PER_WIN)
        ack_err <= 1'b1;
      win_cnt   <= '0;
      win_acks  <= '0;
      win_dirty <= 1'b0;
    end else begin
      win_cnt   <= win_cnt + WW'(1);
      win_acks  <= win_acks_total;
      win_dirty <= win_dirty || (state != ST_RUN);
    end
  end

`ifdef GB_FEED_STATS_EN
  logic [15:0] ucnt_q;
  logic [31:0] bcnt_q;

  // Statistics: saturating underflow count, wrapping block count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ucnt_q <= '0;
      bcnt_q <= '0;
    end else if (restart) begin
      ucnt_q <= '0;
      bcnt_q <= '0;
    end else begin
      if (underflow_evt && ucnt_q != 16'hFFFF) ucnt_q <= ucnt_q + 16'd1;
      if (pop) bcnt_q <= bcnt_q + 32'd1;
    end
  end

  assign underflow_cnt = ucnt_q;
  assign block_cnt     = bcnt_q;
`else
  assign underflow_cnt = '0;
  assign block_cnt     = '0;
`endif

endmodule

// File: tb/tb_gearbox_66_40_feeder.sv
// Scoreboard bench for gearbox_66_40_feeder: randomized blocks and ack
// patterns, a queue-based reference model, and a negedge monitor.
module tb_gearbox_66_40_feeder;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned SCLR  = 4;
  localparam int unsigned PRIME = 2;
  localparam logic [65:0] IDLE  = 66'h79;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        restart;
  logic [65:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [65:0] gb_din;
  logic        gb_sclr;
  logic        gb_ack;
  logic        running;
  logic        underflow;
  logic        ack_err;
  logic [15:0] underflow_cnt;
  logic [31:0] block_cnt;

  gearbox_66_40_feeder dut (
    .clk(clk), .rst_n(rst_n), .restart(restart),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .gb_din(gb_din), .gb_sclr(gb_sclr), .gb_ack(gb_ack),
    .running(running), .underflow(underflow), .ack_err(ack_err),
    .underflow_cnt(underflow_cnt), .block_cnt(block_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum int {P_HOLD, P_PRIME, P_RUN} phase_t;
  phase_t      m_phase;
  int          m_hold_left;
  logic [65:0] m_q[$];
  logic [65:0] exp_q[$];
  bit          m_sclr, m_underflow, m_ack_err;
  int          m_ucnt;
  logic [31:0] m_bcnt;
  int          m_win_pos, m_win_acks;
  bit          m_win_clean;

  task automatic model_clear();
    m_phase = P_HOLD; m_hold_left = SCLR; m_sclr = 1'b1;
    m_q.delete();
    m_underflow = 1'b0; m_ack_err = 1'b0; m_ucnt = 0; m_bcnt = '0;
    m_win_pos = 0; m_win_acks = 0; m_win_clean = 1'b1;
  endtask

  task automatic model_step();
    bit ready;
    int occ0;
    occ0  = m_q.size();
    ready = (m_phase != P_HOLD) && (occ0 < DEPTH);
    if (restart) begin
      if (gb_ack) exp_q.push_back(IDLE);
      model_clear();
      return;
    end
    if (gb_ack) begin
      if (m_phase == P_RUN && m_q.size() > 0) begin
        exp_q.push_back(m_q.pop_front());
        m_bcnt = m_bcnt + 32'd1;
      end else begin
        exp_q.push_back(IDLE);
        if (m_phase == P_RUN) begin
          m_underflow = 1'b1;
          if (m_ucnt < 65535) m_ucnt++;
        end
      end
    end
    if (!m_sclr) begin
      m_win_acks += int'(gb_ack);
      if (m_phase != P_RUN) m_win_clean = 1'b0;
      if (m_win_pos == 32) begin
        if (m_win_clean && m_win_acks != 20) m_ack_err = 1'b1;
        m_win_pos = 0; m_win_acks = 0; m_win_clean = 1'b1;
      end else begin
        m_win_pos++;
      end
    end
    case (m_phase)
      P_HOLD: begin
        if (m_hold_left == 1) begin
          m_phase = P_PRIME; m_sclr = 1'b0;
          m_win_pos = 0; m_win_acks = 0; m_win_clean = 1'b1;
        end else m_hold_left--;
      end
      P_PRIME: if (occ0 >= PRIME) m_phase = P_RUN;
      default: ;
    endcase
    if (in_valid && ready) m_q.push_back(in_data);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_clear();
      exp_q.delete();
    end else begin
      model_step();
    end
  end

  // ---------------- monitor ----------------
  logic mon_ack;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mon_ack <= 1'b0;
    else        mon_ack <= gb_ack;
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (mon_ack) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL gb_din: got %h expected <none, scoreboard empty>", gb_din);
        end else begin
          chk("gb_din", gb_din, exp_q.pop_front());
        end
      end
      chk("gb_sclr", 66'(gb_sclr), 66'(m_sclr));
      chk("running", 66'(running), 66'(m_phase == P_RUN));
      chk("in_ready", 66'(in_ready), 66'((m_phase != P_HOLD) && (m_q.size() < DEPTH)));
      chk("underflow", 66'(underflow), 66'(m_underflow));
      chk("ack_err", 66'(ack_err), 66'(m_ack_err));
`ifdef GB_FEED_STATS_EN
      chk("underflow_cnt", 66'(underflow_cnt), 66'(m_ucnt));
      chk("block_cnt", 66'(block_cnt), 66'(m_bcnt));
`else
      chk("underflow_cnt", 66'(underflow_cnt), 66'(0));
      chk("block_cnt", 66'(block_cnt), 66'(0));
`endif
    end
  end

  // ---------------- stimulus ----------------
  logic [65:0] cur_data;
  int          seq = 1;
  int          n_acc;
  int          cad_acc = 0;

  function automatic bit cad();
    cad_acc += 20;
    if (cad_acc >= 33) begin
      cad_acc -= 33;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic new_data();
    cur_data = {2'b10, 32'($urandom), 32'(seq)};
    seq++;
  endtask

  task automatic cyc(input bit v, input bit a, input bit r);
    bit acc;
    in_valid = v; gb_ack = a; restart = r; in_data = cur_data;
    acc = v && in_ready && !r;
    @(negedge clk);
    if (acc) begin
      n_acc++;
      new_data();
    end
  endtask

  task automatic count_sclr(input int cycles, output int hi);
    hi = 0;
    for (int i = 0; i < cycles; i++) begin
      if (gb_sclr) hi++;
      cyc(1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    int          hi;
    bit          a, dropped;
    logic [65:0] first;
    rst_n = 1'b0; restart = 1'b0; in_valid = 1'b0; gb_ack = 1'b0;
    new_data();
    in_data = cur_data;
    repeat (3) @(negedge clk);
    chk("reset_gb_din", gb_din, IDLE);
    chk("reset_gb_sclr", 66'(gb_sclr), 66'(1));
    chk("reset_in_ready", 66'(in_ready), 66'(0));
    rst_n = 1'b1;

    // Reset/init: sclr held for exactly SCLR cycles, then PRIME idles
    count_sclr(10, hi);
    chk("init_sclr_cycles", 66'(hi), 66'(SCLR));
    chk("prime_gb_din", gb_din, IDLE);
    chk("prime_in_ready", 66'(in_ready), 66'(1));
    chk("prime_running", 66'(running), 66'(0));

    // Steady stream with 20/33 ack cadence
    for (int i = 0; i < 300; i++) cyc(1'b1, cad(), 1'b0);
    chk("stream_underflow", 66'(underflow), 66'(0));
    chk("stream_ack_err", 66'(ack_err), 66'(0));
    chk("stream_running", 66'(running), 66'(1));

    // Starvation: only 5 blocks supplied
    cyc(1'b0, 1'b0, 1'b1);
    n_acc = 0;
    for (int i = 0; i < 120; i++) cyc(n_acc < 5, cad(), 1'b0);
    chk("starve_underflow", 66'(underflow), 66'(1));

    // Backpressure: no acks, FIFO must accept exactly DEPTH blocks
    cyc(1'b0, 1'b0, 1'b1);
    n_acc = 0;
    for (int i = 0; i < 24; i++) cyc(1'b1, 1'b0, 1'b0);
    chk("bp_accepts", 66'(n_acc), 66'(DEPTH));
    chk("bp_in_ready", 66'(in_ready), 66'(0));
    for (int i = 0; i < 200; i++) cyc(($urandom % 4) != 0, cad(), 1'b0);
    for (int i = 0; i < 300; i++) cyc(($urandom % 3) != 0, ($urandom % 5) < 3, 1'b0);

    // Asynchronous reset mid-operation
    in_valid = 1'b1; gb_ack = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_gb_din", gb_din, IDLE);
    chk("async_rst_gb_sclr", 66'(gb_sclr), 66'(1));
    chk("async_rst_running", 66'(running), 66'(0));
    chk("async_rst_underflow", 66'(underflow), 66'(0));
    @(negedge clk);
    in_valid = 1'b0; gb_ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Bad cadence: one window in RUN with 19 acks
    dropped = 1'b0;
    for (int i = 0; i < 150; i++) begin
      a = cad();
      if (i >= 75 && a && !dropped) begin
        a = 1'b0;
        dropped = 1'b1;
      end
      cyc(1'b1, a, 1'b0);
    end
    chk("badcad_ack_err", 66'(ack_err), 66'(1));
    for (int i = 0; i < 40; i++) cyc(1'b1, cad(), 1'b0);
    chk("badcad_ack_err_sticky", 66'(ack_err), 66'(1));

    // Restart clears flags, re-holds sclr, empties the FIFO
    cyc(1'b0, 1'b0, 1'b1);
    chk("restart_ack_err", 66'(ack_err), 66'(0));
    chk("restart_gb_din", gb_din, IDLE);
    count_sclr(SCLR, hi);
    chk("restart_sclr_cycles", 66'(hi), 66'(SCLR));
    chk("restart_sclr_low", 66'(gb_sclr), 66'(0));
    first = cur_data;
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    chk("restart_first_block", gb_din, first);
    for (int i = 0; i < 60; i++) cyc(1'b0, cad(), 1'b0);
    chk("final_underflow", 66'(underflow), 66'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
